// File: rtl/key_adjust.sv
// Up/down/confirm value editor with idle timeout and confirm beep.
// Define KEY_ADJUST_WRAP_EN to wrap at the limits instead of saturating.
module key_adjust #(
  parameter int DATA_W    = 8,
  parameter int MAX_VAL   = 99,
  parameter int TIMEOUT   = 250_000_000,
  parameter int BEEP_LEN  = 5_000_000,
  parameter int BEEP_HALF = 12_500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        key_value,
  output logic [DATA_W-1:0] value_out,
  output logic [DATA_W-1:0] edit_val,
  output logic              editing,
  output logic              commit_pulse,
  output logic              beep_out
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int BL_W = $clog2(BEEP_LEN + 1);
  localparam int PH_W = $clog2(BEEP_HALF + 1);
  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_VAL);
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  state_t            state;
  logic [TO_W-1:0]   tcnt;
  logic [BL_W-1:0]   beep_cnt;
  logic [PH_W-1:0]   ph_cnt;
  logic              beep_on;

  logic key_cf;
  logic key_up;
  logic key_dn;
  logic to_hit;

  assign key_cf = key_value[2];
  assign key_up = (key_value == 3'b001);
  assign key_dn = (key_value == 3'b010);
  assign to_hit = !key_cf && !key_up && !key_dn
                  && (tcnt == TO_W'(TIMEOUT - 1));

  function automatic logic [DATA_W-1:0] inc(
    input logic [DATA_W-1:0] v
  );
`ifdef KEY_ADJUST_WRAP_EN
    return (v >= MAX_V) ? '0 : v + ONE;
`else
    return (v >= MAX_V) ? MAX_V : v + ONE;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] dec(
    input logic [DATA_W-1:0] v
  );
`ifdef KEY_ADJUST_WRAP_EN
    return (v == '0) ? MAX_V : v - ONE;
`else
    return (v == '0) ? '0 : v - ONE;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      value_out    <= '0;
      edit_val     <= '0;
      editing      <= 1'b0;
      commit_pulse <= 1'b0;
      beep_out     <= 1'b0;
      beep_on      <= 1'b0;
      tcnt         <= '0;
      beep_cnt     <= '0;
      ph_cnt       <= '0;
    end else begin
      commit_pulse <= 1'b0;
      // Beep window; a commit below overrides these to restart it.
      if (beep_on) begin
        if (beep_cnt == BL_W'(BEEP_LEN - 1)) begin
          beep_on  <= 1'b0;
          beep_out <= 1'b0;
          beep_cnt <= '0;
          ph_cnt   <= '0;
        end else begin
          beep_cnt <= beep_cnt + 1'b1;
          if (ph_cnt == PH_W'(BEEP_HALF - 1)) begin
            ph_cnt   <= '0;
            beep_out <= ~beep_out;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
      end
      unique case (state)
        IDLE: begin
          tcnt     <= '0;
          edit_val <= value_out;
          if (key_up || key_dn) begin
            edit_val <= key_up ? inc(value_out)
                               : dec(value_out);
            state    <= EDIT;
            editing  <= 1'b1;
          end
        end
        EDIT: begin
          unique case (1'b1)
            key_cf: begin
              value_out    <= edit_val;
              commit_pulse <= 1'b1;
              state        <= IDLE;
              editing      <= 1'b0;
              tcnt         <= '0;
              beep_on      <= 1'b1;
              beep_out     <= 1'b0;
              beep_cnt     <= '0;
              ph_cnt       <= '0;
            end
            key_up: begin
              edit_val <= inc(edit_val);
              tcnt     <= '0;
            end
            key_dn: begin
              edit_val <= dec(edit_val);
              tcnt     <= '0;
            end
            to_hit: begin
              state    <= IDLE;
              editing  <= 1'b0;
              edit_val <= value_out;
              tcnt     <= '0;
            end
            default: tcnt <= tcnt + 1'b1;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
